// File: rtl/ps_loop_seq.sv
// Hardware DO-UNTIL loop sequencer: a small stack of {start, end, count}
// entries that redirects fetch to the loop start until the count expires.
module ps_loop_seq #(
    parameter int AW    = 16,
    parameter int CW    = 16,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     ps_hold,
    input  logic [AW-1:0]            ps_faddr,
    input  logic                     lp_push,
    input  logic [AW-1:0]            lp_start,
    input  logic [AW-1:0]            lp_end,
    input  logic [CW-1:0]            lp_cnt,
    input  logic                     lp_pop,
    output logic                     lp_redir,
    output logic [AW-1:0]            lp_redir_add,
    output logic                     lp_done,
    output logic [CW-1:0]            lp_cntr,
    output logic [$clog2(DEPTH):0]   lp_stkp,
    output logic                     lp_empty,
    output logic                     lp_full,
    output logic                     lp_ovf,
    output logic                     lp_err
);

    localparam int IW = $clog2(DEPTH);
    localparam int PW = IW + 1;

    logic [AW-1:0] start_q [DEPTH];
    logic [AW-1:0] end_q   [DEPTH];
    logic [CW-1:0] cnt_q   [DEPTH];
    logic [PW-1:0] stkp_q, stkp_d;
    logic          ovf_q, ovf_d;
    logic          err_q, err_d;

    logic [IW-1:0] top;
    logic [IW-1:0] widx;
    logic          empty, full;
    logic          match, redir, done;
    logic          pop_req, pop, push_att, push_ok;

    assign top   = IW'(stkp_q - PW'(1));
    assign empty = (stkp_q == '0);
    assign full  = (stkp_q == PW'(DEPTH));

    // Only the top entry is compared, so a shared end address pops one level.
    assign match = !empty && !ps_hold && (ps_faddr == end_q[top]);
    assign redir = match && (cnt_q[top] > CW'(1));
    assign done  = match && (cnt_q[top] == CW'(1));

    always_comb begin
        pop_req  = lp_pop && !empty && !ps_hold;
        pop      = done || pop_req;
        push_att = lp_push && !ps_hold && !pop_req;
        push_ok  = push_att && (lp_cnt != '0) && !full;
        err_d    = push_att && (lp_cnt == '0);
        ovf_d    = ovf_q || (push_att && (lp_cnt != '0) && full);
        widx     = pop ? top : stkp_q[IW-1:0];
        stkp_d   = stkp_q + PW'(push_ok) - PW'(pop);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stkp_q <= '0;
            ovf_q  <= 1'b0;
            err_q  <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                start_q[i] <= '0;
                end_q[i]   <= '0;
                cnt_q[i]   <= '0;
            end
        end else begin
            stkp_q <= stkp_d;
            ovf_q  <= ovf_d;
            err_q  <= err_d;
            if (redir) begin
                cnt_q[top] <= cnt_q[top] - CW'(1);
            end
            // On a termination pop the new entry overwrites the retiring top.
            if (push_ok) begin
                start_q[widx] <= lp_start;
                end_q[widx]   <= lp_end;
                cnt_q[widx]   <= lp_cnt;
            end
        end
    end

    assign lp_redir     = redir;
    assign lp_redir_add = empty ? '0 : start_q[top];
    assign lp_done      = done;
    assign lp_cntr      = empty ? '0 : cnt_q[top];
    assign lp_stkp      = stkp_q;
    assign lp_empty     = empty;
    assign lp_full      = full;
    assign lp_ovf       = ovf_q;
    assign lp_err       = err_q;

endmodule

// File: tb/tb_ps_loop_seq.sv
// Directed self-checking bench for ps_loop_seq.
module tb_ps_loop_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        ps_hold;
    logic [15:0] ps_faddr;
    logic        lp_push;
    logic [15:0] lp_start;
    logic [15:0] lp_end;
    logic [15:0] lp_cnt;
    logic        lp_pop;
    logic        lp_redir;
    logic [15:0] lp_redir_add;
    logic        lp_done;
    logic [15:0] lp_cntr;
    logic [2:0]  lp_stkp;
    logic        lp_empty;
    logic        lp_full;
    logic        lp_ovf;
    logic        lp_err;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    ps_loop_seq #(.AW(16), .CW(16), .DEPTH(4)) dut (
        .clk(clk), .rst(rst), .ps_hold(ps_hold), .ps_faddr(ps_faddr),
        .lp_push(lp_push), .lp_start(lp_start), .lp_end(lp_end),
        .lp_cnt(lp_cnt), .lp_pop(lp_pop), .lp_redir(lp_redir),
        .lp_redir_add(lp_redir_add), .lp_done(lp_done),
        .lp_cntr(lp_cntr), .lp_stkp(lp_stkp), .lp_empty(lp_empty),
        .lp_full(lp_full), .lp_ovf(lp_ovf), .lp_err(lp_err)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        lp_push = 1'b0;
        lp_pop  = 1'b0;
        ps_hold = 1'b0;
    endtask

    task automatic push(input logic [15:0] s, input logic [15:0] e,
                        input logic [15:0] c);
        lp_push  = 1'b1;
        lp_start = s;
        lp_end   = e;
        lp_cnt   = c;
    endtask

    initial begin
        int nredir;
        int nin;
        int nout;
        int ndone;
        logic [15:0] pc;

        idle();
        ps_faddr = 16'h0;
        rst = 1'b0;
        push(16'h10, 16'h13, 16'd3);
        tick();
        tick();
        check("rst_stkp", 32'(lp_stkp), 0);
        check("rst_empty", 32'(lp_empty), 1);
        check("rst_full", 32'(lp_full), 0);
        check("rst_redir", 32'(lp_redir), 0);
        check("rst_add", 32'(lp_redir_add), 0);
        check("rst_done", 32'(lp_done), 0);
        check("rst_cntr", 32'(lp_cntr), 0);
        check("rst_ovf", 32'(lp_ovf), 0);
        check("rst_err", 32'(lp_err), 0);
        rst = 1'b1;
        tick();
        check("rel_stkp", 32'(lp_stkp), 1);
        check("rel_cntr", 32'(lp_cntr), 3);
        idle();

        // basic 3-iteration loop
        nredir = 0;
        for (int p = 1; p <= 3; p++) begin
            for (int a = 16'h10; a <= 16'h13; a++) begin
                ps_faddr = 16'(a);
                #1;
                if (lp_redir) nredir++;
                if (a == 16'h13) begin
                    check("sw_redir", 32'(lp_redir), (p < 3) ? 1 : 0);
                    check("sw_done", 32'(lp_done), (p == 3) ? 1 : 0);
                    if (p < 3) check("sw_add", 32'(lp_redir_add), 32'h10);
                end else begin
                    check("sw_noredir", 32'(lp_redir), 0);
                end
                tick();
            end
            if (p < 3) check("sw_cntr", 32'(lp_cntr), 32'(3 - p));
        end
        check("sw_nredir", 32'(nredir), 2);
        check("sw_stkp", 32'(lp_stkp), 0);
        check("sw_empty", 32'(lp_empty), 1);

        // nested loops driven by a small PC model
        pc = 16'h1F;
        nin = 0;
        nout = 0;
        ndone = 0;
        for (int c = 0; c < 200 && pc != 16'h29; c++) begin
            idle();
            ps_faddr = pc;
            if (pc == 16'h1F) push(16'h20, 16'h28, 16'd2);
            if (pc == 16'h21) push(16'h22, 16'h24, 16'd3);
            #1;
            if (lp_done) ndone++;
            if (lp_redir && lp_redir_add == 16'h22) nin++;
            if (lp_redir && lp_redir_add == 16'h20) nout++;
            pc = lp_redir ? lp_redir_add : pc + 16'h1;
            tick();
        end
        idle();
        check("nest_exit", 32'(pc), 32'h29);
        check("nest_inner", 32'(nin), 4);
        check("nest_outer", 32'(nout), 1);
        check("nest_done", 32'(ndone), 3);
        check("nest_empty", 32'(lp_empty), 1);

        // overflow and zero-count rejection
        ps_faddr = 16'h0;
        for (int i = 0; i < 5; i++) begin
            push(16'(16'h100 + i), 16'(16'h180 + i), 16'd5);
            tick();
            if (i == 3) begin
                check("ov_full4", 32'(lp_full), 1);
                check("ov_ovf4", 32'(lp_ovf), 0);
            end
        end
        idle();
        check("ov_stkp", 32'(lp_stkp), 4);
        check("ov_full", 32'(lp_full), 1);
        check("ov_ovf", 32'(lp_ovf), 1);
        check("ov_add", 32'(lp_redir_add), 32'h103);
        lp_pop = 1'b1;
        tick();
        idle();
        check("ov_pop_stkp", 32'(lp_stkp), 3);
        check("ov_pop_full", 32'(lp_full), 0);
        check("ov_sticky", 32'(lp_ovf), 1);
        push(16'h1, 16'h2, 16'd0);
        tick();
        idle();
        check("err_pulse", 32'(lp_err), 1);
        check("err_stkp", 32'(lp_stkp), 3);
        tick();
        check("err_clear", 32'(lp_err), 0);
        lp_pop = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        idle();
        check("pop_empty_stkp", 32'(lp_stkp), 0);
        check("pop_empty_ovf", 32'(lp_ovf), 1);

        // termination pop with simultaneous push replaces the top
        push(16'h30, 16'h31, 16'd1);
        tick();
        idle();
        ps_faddr = 16'h31;
        push(16'h40, 16'h41, 16'd2);
        #1;
        check("tp_done", 32'(lp_done), 1);
        tick();
        idle();
        check("tp_stkp", 32'(lp_stkp), 1);
        check("tp_cntr", 32'(lp_cntr), 2);
        ps_faddr = 16'h41;
        #1;
        check("tp_redir", 32'(lp_redir), 1);
        check("tp_add", 32'(lp_redir_add), 32'h40);
        tick();
        check("tp_cntr1", 32'(lp_cntr), 1);
        #1;
        check("tp_done2", 32'(lp_done), 1);
        tick();
        check("tp_empty", 32'(lp_empty), 1);

        // hold freezes the match
        ps_faddr = 16'h0;
        push(16'h50, 16'h52, 16'd2);
        tick();
        idle();
        ps_faddr = 16'h52;
        ps_hold = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("hold_redir", 32'(lp_redir), 0);
            tick();
            check("hold_cntr", 32'(lp_cntr), 2);
        end
        ps_hold = 1'b0;
        #1;
        check("hold_rel_redir", 32'(lp_redir), 1);
        tick();
        check("hold_rel_cntr", 32'(lp_cntr), 1);
        tick();
        check("hold_empty", 32'(lp_empty), 1);

        // decrement of old top plus push above it
        ps_faddr = 16'h0;
        push(16'h60, 16'h62, 16'd3);
        tick();
        ps_faddr = 16'h62;
        push(16'h70, 16'h71, 16'd2);
        #1;
        check("dp_redir", 32'(lp_redir), 1);
        tick();
        idle();
        ps_faddr = 16'h0;
        check("dp_stkp", 32'(lp_stkp), 2);
        check("dp_cntr", 32'(lp_cntr), 2);
        lp_pop = 1'b1;
        tick();
        check("dp_old_cntr", 32'(lp_cntr), 2);
        check("dp_old_add", 32'(lp_redir_add), 32'h60);
        push(16'h90, 16'h91, 16'd5);
        tick();
        idle();
        check("pp_stkp", 32'(lp_stkp), 0);

        // one-instruction body
        push(16'h80, 16'h80, 16'd3);
        tick();
        idle();
        ps_faddr = 16'h80;
        nredir = 0;
        ndone = 0;
        for (int i = 0; i < 4; i++) begin
            #1;
            if (lp_redir) nredir++;
            if (lp_done) ndone++;
            tick();
        end
        check("one_redir", 32'(nredir), 2);
        check("one_done", 32'(ndone), 1);
        check("one_empty", 32'(lp_empty), 1);

        // reset mid-loop abandons everything
        ps_faddr = 16'h0;
        push(16'hA0, 16'hA2, 16'd4);
        tick();
        idle();
        rst = 1'b0;
        #1;
        check("mr_empty", 32'(lp_empty), 1);
        check("mr_ovf", 32'(lp_ovf), 0);
        tick();
        rst = 1'b1;
        ps_faddr = 16'hA2;
        #1;
        check("mr_noredir", 32'(lp_redir), 0);
        tick();
        check("mr_stkp", 32'(lp_stkp), 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/ps_loop_seq.md
# ps_loop_seq

Hardware loop sequencer for the program sequencer. It holds a nested DO-UNTIL loop stack of start address, end address and iteration count. Each cycle it compares the fetch address against the top entry's end address. It tells the fetch-address logic to jump back to the loop start until the count runs out, then pops the entry automatically. It sits beside the fetch/decode/PC pipeline, taking the fetch address as input and driving a redirect request, and it reports stack status for the sticky/status registers.

## Interface
- AW, 16, address width (fetch, start and end addresses)
- CW, 16, loop count width
- DEPTH, 4, loop stack entries (power of two, ≥2)

- clk  in  1  clock, all state updates on rising edge
- rst  in  1  reset, asynchronous, active-low
- ps_hold  in  1  sequencer stall; when high, no match, count or stack update takes effect
- ps_faddr  in  AW  current fetch address
- lp_push  in  1  DO-UNTIL decoded; push {lp_start, lp_end, lp_cnt}
- lp_start  in  AW  loop body first address
- lp_end  in  AW  loop body last address
- lp_cnt  in  CW  iteration count
- lp_pop  in  1  explicit pop of top entry (ureg pop instruction)
- lp_redir  out  1  redirect fetch to lp_redir_add next cycle
- lp_redir_add  out  AW  loop start of top entry (0 when stack empty)
- lp_done  out  1  final-iteration end address fetched this cycle
- lp_cntr  out  CW  top entry's remaining count (0 when empty)
- lp_stkp  out  log2(DEPTH)+1  number of valid entries
- lp_empty  out  1  stack empty
- lp_full  out  1  stack full
- lp_ovf  out  1  sticky: push attempted while full
- lp_err  out  1  one-cycle pulse: push with lp_cnt==0 rejected

## Operation
- Match: match = !lp_empty & !ps_hold & (ps_faddr == top.end).
- match & top.cnt > 1: lp_redir=1 and lp_redir_add=top.start, both combinational. At the edge, top.cnt is decremented by 1.
- match & top.cnt == 1: lp_done=1 and lp_redir=0. At the edge the top entry is popped and fetch falls through.
- Push (lp_push & !ps_hold & lp_cnt≠0 & !lp_full): the entry is written at index lp_stkp and lp_stkp increments. The new entry is compared starting the cycle after the push.
- Push while full: ignored and lp_ovf is set. lp_ovf is cleared only by reset.
- Push with lp_cnt==0: ignored and lp_err pulses.
- lp_pop while empty: ignored. Otherwise lp_stkp decrements.
- Simultaneous events, applied at the same edge:
  - termination pop + lp_pop: a single pop.
  - lp_pop + lp_push: pop is performed and push is ignored.
  - termination pop + lp_push: the top is replaced by the new entry and lp_stkp is unchanged.
  - redirect decrement + lp_push: the decrement is applied to the old top, then the push lands above it.
- Shared end address (nested loops ending on the same address): only the top entry is compared. After an inner pop, the outer entry matches only on a later fetch of that address.
- lp_empty = (lp_stkp==0) and lp_full = (lp_stkp==DEPTH), both combinational from the registered pointer.

## Timing
- Reset (async, rst low): lp_stkp=0, all entries cleared, lp_ovf=0. As a result lp_empty=1, lp_full=0, lp_redir=0, lp_redir_add=0, lp_done=0, lp_cntr=0, lp_err=0. Reset mid-loop abandons all loops; no redirect occurs after release.
- lp_redir, lp_redir_add and lp_done are valid in the same cycle as ps_faddr. The sequencer loads lp_redir_add into the fetch address at the next edge, so there is zero added latency.
- lp_cntr, lp_stkp, lp_empty, lp_full and lp_ovf reflect the state after the last edge. lp_err is registered and appears in the cycle after the rejected push.
- A loop of N iterations produces exactly N−1 redirects and one lp_done.
- A one-instruction body (start==end) redirects every cycle until the count is exhausted.
- ps_hold high for k cycles delays all updates by k cycles, with no lost or duplicated decrement.

## Test plan
- Reset while lp_push is held → all outputs at their reset values. After release, push {start=0x0010, end=0x0013, cnt=3} → lp_stkp=1 and lp_cntr=3.
- Sweep fetch 0x0010–0x0013 three times → lp_redir=1 with lp_redir_add=0x0010 at 0x0013 on passes 1 and 2, with lp_cntr reading 2 then 1. On pass 3, lp_done=1 and lp_redir=0, then lp_stkp=0 and lp_empty=1.
- Nest: outer {0x20,0x28,2}, inner {0x22,0x24,3} → exactly 2 inner redirects per outer pass, 4 inner redirects in total, 1 outer redirect, and the stack empty at the end.
- Push 5 entries with DEPTH=4 → lp_full=1, lp_stkp=4, lp_ovf=1 (sticky through later pops). Push with cnt=0 → lp_err pulses once and lp_stkp is unchanged.
- Termination match on cnt=1 in the same cycle as lp_push {0x40,0x41,2} → lp_stkp unchanged, and lp_redir_add becomes 0x40 on the next match.
- ps_hold asserted for 3 cycles with ps_faddr==end and cnt=2 → lp_redir=0 and lp_cntr=2 while held. After release, one redirect occurs and lp_cntr becomes 1.
